multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the 16-bit processor. Sequences each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes, including alu_src_b, which
//  drives the Selector of the ALU B-operand 2:1 mux (0 = register data 2, 1 = sign-extended
//  immediate). It also handles memory wait states with a timeout, halt/fault, and a retire counter.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive mem_ready=0 cycles in FETCH/MEM before fault
//  CNTW         16  width of the retired-instruction counter
// PORTS
//  clk          in   1     single clock, rising edge
//  reset        in   1     synchronous, active-high
//  run          in   1     start/continue enable, sampled in IDLE and at retire
//  instr_op     in   4     opcode field [15:12] of instruction-memory data, valid with mem_ready
//  mem_ready    in   1     memory handshake: current read/write completes this cycle
//  zero         in   1     ALU zero flag, valid in EXEC
//  pc_write     out  1     PC register load enable
//  pc_src       out  1     0 = PC+1, 1 = branch target
//  ir_write     out  1     instruction register load enable
//  alu_src_b    out  1     ALU B mux select (0 = reg data 2, 1 = sign-extended imm)
//  alu_op       out  2     00 ADD, 01 SUB, 10 AND, 11 OR
//  reg_write    out  1     register-file write enable
//  mem_to_reg   out  1     write-back source (0 = ALU, 1 = memory)
//  mem_read     out  1     memory read request
//  mem_write    out  1     memory write request
//  halted       out  1     sticky, set in HALT
//  fault        out  1     sticky, set on illegal opcode or timeout
//  instr_count  out  CNTW  retired instructions, wraps modulo 2^CNTW
// BEHAVIOUR
//  - Sync reset: state=IDLE, opcode reg=0, wait_cnt=0, instr_count=0, halted=fault=0.
//    While reset=1, every strobe output is forced to 0 in the same cycle.
//  - Strobes are Moore outputs, decoded from the current state and the latched opcode.
//    The exception is FETCH/MEM completion, which is qualified by mem_ready.
//  - Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, F HLT, 8-E illegal.
//  - IDLE: all strobes 0. Go to FETCH when run=1.
//  - FETCH: mem_read=1. On mem_ready=1: ir_write=pc_write=1, pc_src=0, latch instr_op,
//    then go to DECODE. Otherwise stay and increment wait_cnt.
//  - DECODE: one cycle, no strobes.
//    Opcode F -> HALT. Opcodes 8-E -> HALT and set fault. All others -> EXEC.
//  - EXEC: alu_src_b=0 for opcodes 0-3 and BEQ; alu_src_b=1 for ADDI, LW and SW.
//    alu_op = opcode[1:0] for opcodes 0-3, SUB for BEQ, ADD otherwise.
//    Next state: opcodes 0-4 -> WB; LW/SW -> MEM.
//    BEQ: pc_write=zero, pc_src=1, then retire.
//  - MEM: LW drives mem_read=1; SW drives mem_write=1. Hold until mem_ready=1.
//    LW then goes to WB; SW retires.
//  - WB: reg_write=1; mem_to_reg=1 for LW only. Then retire.
//  - Retire: instr_count+1; next state is FETCH if run=1, else IDLE.
//    Latency: R/ADDI 4, BEQ 3, SW 4, LW 5 cycles (with zero wait states).
//  - wait_cnt clears on entry to FETCH/MEM and on mem_ready=1. When it reaches MEM_TIMEOUT
//    with mem_ready=0: go to HALT and set fault. If mem_ready=1 in that cycle, ready wins.
//  - HALT: all strobes 0, halted=1. Leaves only on reset; run is ignored.
//  - run=0 mid-instruction does not abort it; it takes effect at retire.
//  - Reset mid-instruction: the in-flight instruction is abandoned and does not count.
//  - instr_count wraps from 2^CNTW-1 to 0 without saturating.
// STRUCTURE
//  - Package ctrl_pkg: state encodings (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT as 3-bit
//    localparams), opcode constants, ALU_ADD/SUB/AND/OR, ALU_SRC_REG=0, ALU_SRC_IMM=1.
//  - Sub-module ctrl_decode (combinational): latched opcode -> class bits
//    {rtype, addi, lw, sw, beq, hlt, illegal} and the EXEC-phase alu_op/alu_src_b.
//  - Top holds the state register, opcode register, wait_cnt, sticky flags, counter and
//    strobe decode.
// TESTING
//  1. reset, run=1, mem_ready=1, ADD(0) -> states FETCH,DECODE,EXEC,WB,FETCH;
//     alu_src_b=0 in EXEC; reg_write=1 in WB only; instr_count=1.
//  2. ADDI(4), then LW(5) with mem_ready low 3 cycles in MEM -> alu_src_b=1 in both EXECs;
//     MEM held 4 cycles; mem_to_reg=1 in WB; instr_count=2.
//  3. BEQ(7) with zero=1, then BEQ with zero=0 -> pc_write=1/pc_src=1 in the first EXEC;
//     pc_write=0 in the second; each takes 3 cycles.
//  4. mem_ready=0 held in FETCH -> fault=1 and halted=1 after MEM_TIMEOUT=15 cycles;
//     run ignored until reset. Repeat with mem_ready=1 on the 15th cycle -> no fault.
//  5. opcode 9 -> HALT with fault=1. Opcode F -> halted=1 with fault=0.
//     Reset asserted in MEM of SW -> mem_write=0 that cycle, IDLE next cycle, instr_count=0.
//  6. Preload instr_count=16'hFFFF via forced retires, then retire once -> 16'h0000.
//     run=0 during EXEC -> instruction completes, then IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle control FSM of the 16-bit processor:
// state encodings, opcode values, ALU operation codes, ALU B-operand select
// values and the opcode class struct produced by the decoder.
// No ports (package).
// ---------------------------------------------------------------------------
package ctrl_pkg;

    // Raw 3-bit state encodings; the enum below is built on these values so
    // the debug output can be compared against plain numbers as well.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_FETCH  = S_FETCH,
        ST_DECODE = S_DECODE,
        ST_EXEC   = S_EXEC,
        ST_MEM    = S_MEM,
        ST_WB     = S_WB,
        ST_HALT   = S_HALT
    } state_t;

    // Opcode field [15:12]; 8..E are illegal.
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // ALU B-operand 2:1 mux select.
    localparam logic ALU_SRC_REG = 1'b0;
    localparam logic ALU_SRC_IMM = 1'b1;

    // Exactly one bit is set for any opcode value.
    typedef struct packed {
        logic rtype;
        logic addi;
        logic lw;
        logic sw;
        logic beq;
        logic hlt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundles the controller's datapath/memory-facing signals.
//   slave  : the controller (inputs run/instr_op/mem_ready/zero, drives strobes)
//   master : the surrounding datapath / environment
// Signals: run, instr_op[3:0], mem_ready, zero (to controller);
//          pc_write, pc_src, ir_write, alu_src_b, alu_op[1:0], reg_write,
//          mem_to_reg, mem_read, mem_write, halted, fault, instr_count[CNTW-1:0],
//          dbg_state (from controller).
// Handshake: a memory access (mem_read or mem_write high) completes in the
// cycle where mem_ready is also high; the controller holds the request until
// then, and mem_ready outside FETCH/MEM is ignored.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if
    import ctrl_pkg::*;
#(
    parameter int CNTW = 16
);
    logic            run;
    logic [3:0]      instr_op;
    logic            mem_ready;
    logic            zero;
    logic            pc_write;
    logic            pc_src;
    logic            ir_write;
    logic            alu_src_b;
    logic [1:0]      alu_op;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic            halted;
    logic            fault;
    logic [CNTW-1:0] instr_count;
    state_t          dbg_state;

    modport slave (
        input  run, instr_op, mem_ready, zero,
        output pc_write, pc_src, ir_write, alu_src_b, alu_op, reg_write,
               mem_to_reg, mem_read, mem_write, halted, fault, instr_count,
               dbg_state
    );

    modport master (
        output run, instr_op, mem_ready, zero,
        input  pc_write, pc_src, ir_write, alu_src_b, alu_op, reg_write,
               mem_to_reg, mem_read, mem_write, halted, fault, instr_count,
               dbg_state
    );

endinterface

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Combinational decode of the latched opcode into instruction class bits and
// the EXEC-phase ALU controls.
//   i_opcode    in  4  latched opcode
//   o_class     out    {rtype, addi, lw, sw, beq, hlt, illegal}
//   o_alu_op    out 2  ALU operation used in EXEC
//   o_alu_src_b out 1  ALU B mux select used in EXEC
// ---------------------------------------------------------------------------
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_class,
    output logic [1:0] o_alu_op,
    output logic       o_alu_src_b
);

    always_comb begin
        o_class     = '0;
        o_alu_op    = ALU_ADD;
        o_alu_src_b = ALU_SRC_REG;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                o_class.rtype = 1'b1;
                // R-type opcodes are numbered to match the ALU op encoding.
                o_alu_op      = i_opcode[1:0];
            end
            OP_ADDI: begin
                o_class.addi = 1'b1;
                o_alu_src_b  = ALU_SRC_IMM;
            end
            OP_LW: begin
                o_class.lw  = 1'b1;
                o_alu_src_b = ALU_SRC_IMM;
            end
            OP_SW: begin
                o_class.sw  = 1'b1;
                o_alu_src_b = ALU_SRC_IMM;
            end
            OP_BEQ: begin
                o_class.beq = 1'b1;
                o_alu_op    = ALU_SUB;
            end
            OP_HLT: o_class.hlt = 1'b1;
            default: o_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle control FSM: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath strobes, times out stalled
// memory accesses, and keeps sticky halt/fault flags plus a retire counter.
//   clk    in  1   rising-edge clock
//   reset  in  1   synchronous, active-high; strobes are forced low while high
//   bus    slave modport of multicycle_ctrl_if (see that file for signals)
// Parameters:
//   MEM_TIMEOUT  consecutive mem_ready=0 cycles in FETCH/MEM before fault
//   CNTW         retire counter width (must match the interface CNTW)
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNTW        = 16
)(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.slave  bus
);

    localparam int WTW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t          r_state;
    logic [3:0]      r_opcode;
    logic [WTW-1:0]  r_wait;
    logic [CNTW-1:0] r_instr_count;
    logic            r_halted;
    logic            r_fault;

    state_t          w_next;
    logic            w_latch;
    logic            w_retire;
    logic            w_set_fault;
    logic            w_timeout;
    op_class_t       w_class;
    logic [1:0]      w_exec_alu_op;
    logic            w_exec_alu_src_b;

    logic            w_pc_write;
    logic            w_pc_src;
    logic            w_ir_write;
    logic            w_alu_src_b;
    logic [1:0]      w_alu_op;
    logic            w_reg_write;
    logic            w_mem_to_reg;
    logic            w_mem_read;
    logic            w_mem_write;

    ctrl_decode u_decode (
        .i_opcode    (r_opcode),
        .o_class     (w_class),
        .o_alu_op    (w_exec_alu_op),
        .o_alu_src_b (w_exec_alu_src_b)
    );

    // r_wait holds the number of stall cycles already spent in this access,
    // so this cycle is the MEM_TIMEOUT-th stall when it equals MEM_TIMEOUT-1.
    assign w_timeout = (r_wait == WTW'(MEM_TIMEOUT - 1));

    // Next-state logic.
    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_retire    = 1'b0;
        w_set_fault = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.run) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    w_next  = ST_DECODE;
                    w_latch = 1'b1;
                end else if (w_timeout) begin
                    w_next      = ST_HALT;
                    w_set_fault = 1'b1;
                end
            end
            ST_DECODE: begin
                if (w_class.hlt) begin
                    w_next = ST_HALT;
                end else if (w_class.illegal) begin
                    w_next      = ST_HALT;
                    w_set_fault = 1'b1;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_class.rtype || w_class.addi) begin
                    w_next = ST_WB;
                end else if (w_class.lw || w_class.sw) begin
                    w_next = ST_MEM;
                end else if (w_class.beq) begin
                    w_retire = 1'b1;
                end else begin
                    // Unreachable: DECODE filters HLT/illegal before EXEC.
                    w_next      = ST_HALT;
                    w_set_fault = 1'b1;
                end
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    if (w_class.lw) w_next = ST_WB;
                    else            w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next      = ST_HALT;
                    w_set_fault = 1'b1;
                end
            end
            ST_WB: begin
                w_retire = 1'b1;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // run is only looked at between instructions.
        if (w_retire) w_next = bus.run ? ST_FETCH : ST_IDLE;
    end

    // State register and bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_opcode      <= '0;
            r_wait        <= '0;
            r_instr_count <= '0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) r_opcode <= bus.instr_op;
            // Counting only while stalled in FETCH/MEM also clears the counter
            // on entry to either state and whenever mem_ready completes.
            if ((r_state == ST_FETCH || r_state == ST_MEM) && !bus.mem_ready)
                r_wait <= r_wait + WTW'(1);
            else
                r_wait <= '0;
            if (w_retire) r_instr_count <= r_instr_count + CNTW'(1);
            if (w_next == ST_HALT) r_halted <= 1'b1;
            if (w_set_fault) r_fault <= 1'b1;
        end
    end

    // Strobe decode: Moore on state/opcode, except FETCH completion.
    always_comb begin
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_ir_write   = 1'b0;
        w_alu_src_b  = ALU_SRC_REG;
        w_alu_op     = ALU_ADD;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    w_mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        w_ir_write = 1'b1;
                        w_pc_write = 1'b1;
                        w_pc_src   = 1'b0;
                    end
                end
                ST_EXEC: begin
                    w_alu_src_b = w_exec_alu_src_b;
                    w_alu_op    = w_exec_alu_op;
                    if (w_class.beq) begin
                        w_pc_write = bus.zero;
                        w_pc_src   = 1'b1;
                    end
                end
                ST_MEM: begin
                    w_mem_read  = w_class.lw;
                    w_mem_write = w_class.sw;
                end
                ST_WB: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = w_class.lw;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.pc_src      = w_pc_src;
    assign bus.ir_write    = w_ir_write;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.alu_op      = w_alu_op;
    assign bus.reg_write   = w_reg_write;
    assign bus.mem_to_reg  = w_mem_to_reg;
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.halted      = r_halted;
    assign bus.fault       = r_fault;
    assign bus.instr_count = r_instr_count;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Inputs change 1 time unit after a rising
// edge; outputs are sampled a further unit later, well away from the edge.
// A second instance with a 2-bit retire counter exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst2 = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNTW(16)) u_bus ();
    multicycle_ctrl_if #(.CNTW(2))  u_wbus ();

    multicycle_ctrl #(.MEM_TIMEOUT(15), .CNTW(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_bus)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(15), .CNTW(2)) u_wrap (
        .clk   (clk),
        .reset (rst2),
        .bus   (u_wbus)
    );

    // Strobe vector: [9]pc_write [8]pc_src [7]ir_write [6]alu_src_b
    // [5:4]alu_op [3]reg_write [2]mem_to_reg [1]mem_read [0]mem_write
    localparam logic [9:0] V_NONE  = 10'b0000000000;
    localparam logic [9:0] V_FRDY  = 10'b1010000010;
    localparam logic [9:0] V_FWAIT = 10'b0000000010;
    localparam logic [9:0] V_EXSUB = 10'b0000010000;
    localparam logic [9:0] V_EXOR  = 10'b0000110000;
    localparam logic [9:0] V_EXIMM = 10'b0001000000;
    localparam logic [9:0] V_BEQ1  = 10'b1100010000;
    localparam logic [9:0] V_BEQ0  = 10'b0100010000;
    localparam logic [9:0] V_WBR   = 10'b0000001000;
    localparam logic [9:0] V_WBLW  = 10'b0000001100;
    localparam logic [9:0] V_MLW   = 10'b0000000010;
    localparam logic [9:0] V_MSW   = 10'b0000000001;

    function automatic logic [9:0] strb();
        return {u_bus.pc_write, u_bus.pc_src, u_bus.ir_write, u_bus.alu_src_b,
                u_bus.alu_op, u_bus.reg_write, u_bus.mem_to_reg,
                u_bus.mem_read, u_bus.mem_write};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check state and strobes in the current cycle, then advance one cycle.
    task automatic at(input string tag, input state_t st, input logic [9:0] s);
        #1;
        check({tag, "_st"}, 32'(u_bus.dbg_state), 32'(st));
        check({tag, "_strb"}, 32'(strb()), 32'(s));
        cyc();
    endtask

    task automatic flags(input string tag, input logic [15:0] cnt, input logic h, input logic f);
        #1;
        check({tag, "_cnt"}, 32'(u_bus.instr_count), 32'(cnt));
        check({tag, "_halted"}, 32'(u_bus.halted), 32'(h));
        check({tag, "_fault"}, 32'(u_bus.fault), 32'(f));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        u_bus.run = 1'b0;
        u_bus.mem_ready = 1'b0;
        u_bus.zero = 1'b0;
        u_bus.instr_op = 4'h0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        u_wbus.run = 1'b1;
        u_wbus.mem_ready = 1'b1;
        u_wbus.instr_op = OP_BEQ;
        u_wbus.zero = 1'b0;

        // Reset state.
        do_reset();
        flags("rst", 16'd0, 1'b0, 1'b0);
        at("rst", ST_IDLE, V_NONE);

        // 1: ADD, SUB, OR back to back.
        do_reset();
        u_bus.run = 1'b1; u_bus.mem_ready = 1'b1; u_bus.instr_op = OP_ADD;
        at("t1_idle", ST_IDLE, V_NONE);
        at("t1_f", ST_FETCH, V_FRDY);
        at("t1_d", ST_DECODE, V_NONE);
        at("t1_e", ST_EXEC, V_NONE);
        at("t1_wb", ST_WB, V_WBR);
        flags("t1", 16'd1, 1'b0, 1'b0);
        u_bus.instr_op = OP_SUB;
        at("t1s_f", ST_FETCH, V_FRDY);
        at("t1s_d", ST_DECODE, V_NONE);
        at("t1s_e", ST_EXEC, V_EXSUB);
        at("t1s_wb", ST_WB, V_WBR);
        u_bus.instr_op = OP_OR;
        at("t1o_f", ST_FETCH, V_FRDY);
        at("t1o_d", ST_DECODE, V_NONE);
        at("t1o_e", ST_EXEC, V_EXOR);
        at("t1o_wb", ST_WB, V_WBR);
        flags("t1o", 16'd3, 1'b0, 1'b0);

        // 2: ADDI then LW with three MEM wait cycles.
        do_reset();
        u_bus.run = 1'b1; u_bus.mem_ready = 1'b1; u_bus.instr_op = OP_ADDI;
        at("t2_idle", ST_IDLE, V_NONE);
        at("t2a_f", ST_FETCH, V_FRDY);
        at("t2a_d", ST_DECODE, V_NONE);
        at("t2a_e", ST_EXEC, V_EXIMM);
        at("t2a_wb", ST_WB, V_WBR);
        u_bus.instr_op = OP_LW;
        at("t2l_f", ST_FETCH, V_FRDY);
        at("t2l_d", ST_DECODE, V_NONE);
        at("t2l_e", ST_EXEC, V_EXIMM);
        u_bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) at("t2l_mwait", ST_MEM, V_MLW);
        u_bus.mem_ready = 1'b1;
        at("t2l_m", ST_MEM, V_MLW);
        at("t2l_wb", ST_WB, V_WBLW);
        #1;
        check("t2_next", 32'(u_bus.dbg_state), 32'(ST_FETCH));
        flags("t2", 16'd2, 1'b0, 1'b0);

        // 3: BEQ taken then not taken, 3 cycles each.
        do_reset();
        u_bus.run = 1'b1; u_bus.mem_ready = 1'b1; u_bus.instr_op = OP_BEQ;
        at("t3_idle", ST_IDLE, V_NONE);
        at("t3a_f", ST_FETCH, V_FRDY);
        at("t3a_d", ST_DECODE, V_NONE);
        u_bus.zero = 1'b1;
        at("t3a_e", ST_EXEC, V_BEQ1);
        u_bus.zero = 1'b0;
        at("t3b_f", ST_FETCH, V_FRDY);
        at("t3b_d", ST_DECODE, V_NONE);
        at("t3b_e", ST_EXEC, V_BEQ0);
        #1;
        check("t3_next", 32'(u_bus.dbg_state), 32'(ST_FETCH));
        flags("t3", 16'd2, 1'b0, 1'b0);

        // 4: FETCH timeout, then ready on the 15th cycle.
        do_reset();
        u_bus.run = 1'b1; u_bus.mem_ready = 1'b0;
        at("t4_idle", ST_IDLE, V_NONE);
        for (int i = 0; i < 15; i++) at("t4_fwait", ST_FETCH, V_FWAIT);
        flags("t4_to", 16'd0, 1'b1, 1'b1);
        u_bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) at("t4_halt", ST_HALT, V_NONE);
        do_reset();
        u_bus.run = 1'b1; u_bus.mem_ready = 1'b0;
        at("t4b_idle", ST_IDLE, V_NONE);
        for (int i = 0; i < 14; i++) at("t4b_fwait", ST_FETCH, V_FWAIT);
        u_bus.mem_ready = 1'b1;
        at("t4b_f", ST_FETCH, V_FRDY);
        at("t4b_d", ST_DECODE, V_NONE);
        flags("t4b", 16'd0, 1'b0, 1'b0);

        // 5: illegal opcode, HLT, reset during SW MEM.
        do_reset();
        u_bus.run = 1'b1; u_bus.mem_ready = 1'b1; u_bus.instr_op = 4'h9;
        at("t5i_idle", ST_IDLE, V_NONE);
        at("t5i_f", ST_FETCH, V_FRDY);
        at("t5i_d", ST_DECODE, V_NONE);
        at("t5i_h", ST_HALT, V_NONE);
        flags("t5i", 16'd0, 1'b1, 1'b1);
        do_reset();
        u_bus.run = 1'b1; u_bus.mem_ready = 1'b1; u_bus.instr_op = OP_HLT;
        at("t5h_idle", ST_IDLE, V_NONE);
        at("t5h_f", ST_FETCH, V_FRDY);
        at("t5h_d", ST_DECODE, V_NONE);
        at("t5h_h", ST_HALT, V_NONE);
        flags("t5h", 16'd0, 1'b1, 1'b0);
        do_reset();
        u_bus.run = 1'b1; u_bus.mem_ready = 1'b1; u_bus.instr_op = OP_SW;
        at("t5s_idle", ST_IDLE, V_NONE);
        at("t5s_f", ST_FETCH, V_FRDY);
        at("t5s_d", ST_DECODE, V_NONE);
        at("t5s_e", ST_EXEC, V_EXIMM);
        at("t5s_m", ST_MEM, V_MSW);
        // Second SW: reset lands in its MEM cycle.
        at("t5s2_f", ST_FETCH, V_FRDY);
        at("t5s2_d", ST_DECODE, V_NONE);
        at("t5s2_e", ST_EXEC, V_EXIMM);
        flags("t5s_pre", 16'd1, 1'b0, 1'b0);
        reset = 1'b1;
        at("t5s_rstmem", ST_MEM, V_NONE);
        reset = 1'b0;
        u_bus.run = 1'b0;
        flags("t5s_post", 16'd0, 1'b0, 1'b0);
        at("t5s_idle2", ST_IDLE, V_NONE);

        // 6a: run dropped in EXEC lets the instruction finish, then IDLE.
        do_reset();
        u_bus.run = 1'b1; u_bus.mem_ready = 1'b1; u_bus.instr_op = OP_ADD;
        at("t6_idle", ST_IDLE, V_NONE);
        at("t6_f", ST_FETCH, V_FRDY);
        at("t6_d", ST_DECODE, V_NONE);
        u_bus.run = 1'b0;
        at("t6_e", ST_EXEC, V_NONE);
        at("t6_wb", ST_WB, V_WBR);
        at("t6_idle2", ST_IDLE, V_NONE);
        at("t6_idle3", ST_IDLE, V_NONE);
        flags("t6", 16'd1, 1'b0, 1'b0);

        // 6b: counter wrap on the 2-bit instance, BEQ retires every 3 cycles.
        rst2 = 1'b1;
        cyc();
        rst2 = 1'b0;
        #1;
        check("wrap_rst", 32'(u_wbus.instr_count), 32'd0);
        cyc();
        repeat (9) cyc();
        #1;
        check("wrap_max", 32'(u_wbus.instr_count), 32'd3);
        cyc();
        repeat (3) cyc();
        #1;
        check("wrap_zero", 32'(u_wbus.instr_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
